// File: rtl/sw_debounce.sv
// sw_debounce
//   Input conditioner for the slide-switch bank. Each raw SW bit is brought
//   into the CLOCK_50 domain through a two-flop synchroniser. It is then
//   debounced with its own stability counter. A new level is accepted only
//   after it has held for CNT_MAX consecutive cycles at the synchroniser
//   output.
//
// Parameters
//   WIDTH    number of switch bits conditioned
//   CNT_MAX  consecutive cycles a new level must hold before acceptance
//            (legal range 1 .. 2^24-1)
//
// Ports
//   CLOCK_50  in   1      system clock, all state on rising edge
//   resetn    in   1      asynchronous active-low reset
//   SW        in   WIDTH  raw asynchronous switch levels
//   sw_clean  out  WIDTH  debounced switch levels (registered)
//   sw_rise   out  WIDTH  one-cycle pulse when a sw_clean bit goes 0->1
//   sw_fall   out  WIDTH  one-cycle pulse when a sw_clean bit goes 1->0
//   stable    out  1      high when every synchronised bit equals sw_clean

module sw_debounce #(
    parameter int WIDTH   = 10,
    parameter int CNT_MAX = 500000
) (
    input  logic             CLOCK_50,
    input  logic             resetn,
    input  logic [WIDTH-1:0] SW,
    output logic [WIDTH-1:0] sw_clean,
    output logic [WIDTH-1:0] sw_rise,
    output logic [WIDTH-1:0] sw_fall,
    output logic             stable
);

    localparam int               CNT_W    = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic [CNT_W-1:0] cnt [WIDTH];

    // Two-flop synchroniser. Only sync2 is used downstream.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= SW;
            sync2 <= sync1;
        end
    end

    // Per-bit stability counter. A differing level is accepted on the edge
    // where the counter already sits at CNT_LAST. So the change must be seen
    // on CNT_MAX consecutive edges. Any agreeing edge discards the progress.
    // Pulses default low every edge, so each pulse is exactly one cycle wide.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            sw_clean <= '0;
            sw_rise  <= '0;
            sw_fall  <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                sw_rise[i] <= 1'b0;
                sw_fall[i] <= 1'b0;
                if (sync2[i] == sw_clean[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    sw_clean[i] <= sync2[i];
                    sw_rise[i]  <= sync2[i];
                    sw_fall[i]  <= ~sync2[i];
                    cnt[i]      <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CNT_ONE;
                end
            end
        end
    end

    assign stable = (sync2 == sw_clean);

endmodule

// File: tb/tb_sw_debounce.sv
// tb_sw_debounce
//   Self-checking bench for sw_debounce. The main instance uses WIDTH=10 and
//   CNT_MAX=4. A second instance uses WIDTH=1 and CNT_MAX=1, so it exercises
//   the "track with one cycle lag" corner.
//
//   The reference model works from the observable rules, not the RTL:
//   - The synchronised level seen at an edge is the SW value sampled two edges
//     earlier. It is held in a small queue.
//   - A bit is accepted once its disagreement with the clean level has lasted
//     CNT_MAX edges. This is measured with edge timestamps.
//
//   Every edge, both instances are compared against the model. Directed
//   constant checks cover the boundary cases.

module tb_sw_debounce;

    localparam int W  = 10;
    localparam int CM = 4;

    logic         clk = 1'b0;
    logic         resetn;
    logic [W-1:0] sw;
    logic [W-1:0] sw_clean, sw_rise, sw_fall;
    logic         stable;

    logic         sw1;
    logic [0:0]   clean1, rise1, fall1;
    logic         stable1;

    int checks = 0;
    int errors = 0;
    int edge_no = 0;

    // Model state for the CNT_MAX=4 instance
    logic [W-1:0] m_pipe [$];
    logic [W-1:0] m_clean, m_rise, m_fall;
    int           m_since [W];

    // Model state for the CNT_MAX=1 instance
    logic         p1_pipe [$];
    logic         m1_clean, m1_rise, m1_fall;

    always #10 clk = ~clk;

    sw_debounce #(.WIDTH(W), .CNT_MAX(CM)) dut (
        .CLOCK_50 (clk),
        .resetn   (resetn),
        .SW       (sw),
        .sw_clean (sw_clean),
        .sw_rise  (sw_rise),
        .sw_fall  (sw_fall),
        .stable   (stable)
    );

    sw_debounce #(.WIDTH(1), .CNT_MAX(1)) dut1 (
        .CLOCK_50 (clk),
        .resetn   (resetn),
        .SW       (sw1),
        .sw_clean (clean1),
        .sw_rise  (rise1),
        .sw_fall  (fall1),
        .stable   (stable1)
    );

    task automatic checkOutput(input string tag, input logic [W-1:0] obs,
                               input logic [W-1:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h (edge %0d)",
                   tag, obs, exp, edge_no);
        end
    endtask

    task automatic modelReset();
        m_pipe.delete();
        m_pipe.push_back('0);
        m_pipe.push_back('0);
        p1_pipe.delete();
        p1_pipe.push_back(1'b0);
        p1_pipe.push_back(1'b0);
        m_clean  = '0;
        m_rise   = '0;
        m_fall   = '0;
        m1_clean = 1'b0;
        m1_rise  = 1'b0;
        m1_fall  = 1'b0;
        for (int i = 0; i < W; i++) m_since[i] = -1;
    endtask

    // Advances both models by one rising edge, using the inputs present at it.
    task automatic modelEdge();
        logic [W-1:0] s;
        logic         s1;
        edge_no++;
        s      = m_pipe[0];
        m_rise = '0;
        m_fall = '0;
        for (int i = 0; i < W; i++) begin
            if (s[i] == m_clean[i]) begin
                m_since[i] = -1;
            end else begin
                if (m_since[i] < 0) m_since[i] = edge_no;
                if (edge_no - m_since[i] + 1 >= CM) begin
                    m_clean[i] = s[i];
                    m_rise[i]  = s[i];
                    m_fall[i]  = ~s[i];
                    m_since[i] = -1;
                end
            end
        end
        void'(m_pipe.pop_front());
        m_pipe.push_back(sw);

        s1       = p1_pipe[0];
        m1_rise  = s1 & ~m1_clean;
        m1_fall  = ~s1 & m1_clean;
        m1_clean = s1;
        void'(p1_pipe.pop_front());
        p1_pipe.push_back(sw1);
    endtask

    task automatic compareModel(input string where);
        checkOutput({where, ":clean"},   sw_clean, m_clean);
        checkOutput({where, ":rise"},    sw_rise,  m_rise);
        checkOutput({where, ":fall"},    sw_fall,  m_fall);
        checkOutput({where, ":stable"},  {9'b0, stable},  {9'b0, m_pipe[0] == m_clean});
        checkOutput({where, ":clean1"},  {9'b0, clean1},  {9'b0, m1_clean});
        checkOutput({where, ":rise1"},   {9'b0, rise1},   {9'b0, m1_rise});
        checkOutput({where, ":fall1"},   {9'b0, fall1},   {9'b0, m1_fall});
        checkOutput({where, ":stable1"}, {9'b0, stable1}, {9'b0, p1_pipe[0] == m1_clean});
    endtask

    task automatic tick();
        @(posedge clk);
        modelEdge();
        #1;
        compareModel("step");
    endtask

    task automatic applyStimulus(input logic [W-1:0] sw_val, input logic sw1_val,
                                 input int cycles);
        sw  = sw_val;
        sw1 = sw1_val;
        repeat (cycles) tick();
    endtask

    // Resets for one clock while the inputs keep their current values.
    task automatic resetPulse();
        resetn = 1'b0;
        #1;
        modelReset();
        compareModel("reset");
        checkOutput("reset_clean", sw_clean, '0);
        @(posedge clk);
        #1;
        resetn = 1'b1;
    endtask

    initial begin
        logic [W-1:0] sw_r;
        logic [W-1:0] mask;
        logic         s1v;

        resetn = 1'b0;
        sw     = '0;
        sw1    = 1'b0;
        modelReset();
        #5;
        compareModel("por");
        checkOutput("por_stable", {9'b0, stable}, 10'h001);
        @(posedge clk);
        #1;
        resetn = 1'b1;

        // 1: all switches high from reset; accepted after edge 6
        applyStimulus(10'h3FF, 1'b0, 1);
        checkOutput("t1_e1_stable", {9'b0, stable}, 10'h001);
        applyStimulus(10'h3FF, 1'b0, 1);
        checkOutput("t1_e2_stable", {9'b0, stable}, 10'h000);
        applyStimulus(10'h3FF, 1'b0, 3);
        checkOutput("t1_e5_clean", sw_clean, 10'h000);
        checkOutput("t1_e5_stable", {9'b0, stable}, 10'h000);
        applyStimulus(10'h3FF, 1'b0, 1);
        checkOutput("t1_e6_clean", sw_clean, 10'h3FF);
        checkOutput("t1_e6_rise", sw_rise, 10'h3FF);
        checkOutput("t1_e6_stable", {9'b0, stable}, 10'h001);
        applyStimulus(10'h3FF, 1'b0, 1);
        checkOutput("t1_e7_rise", sw_rise, 10'h000);

        // 2: back to clean 0, then a 3-cycle glitch on bit 0 is rejected
        applyStimulus(10'h000, 1'b0, 8);
        checkOutput("t2_base", sw_clean, 10'h000);
        applyStimulus(10'h001, 1'b0, 3);
        applyStimulus(10'h000, 1'b0, 8);
        checkOutput("t2_glitch", sw_clean, 10'h000);
        // A cleared counter means a real change still needs the full latency
        applyStimulus(10'h001, 1'b0, 5);
        checkOutput("t2_hold5", sw_clean, 10'h000);
        applyStimulus(10'h001, 1'b0, 1);
        checkOutput("t2_hold6", sw_clean, 10'h001);

        // 3: simultaneous rise on bit 0 and fall on bit 9
        applyStimulus(10'h200, 1'b0, 10);
        checkOutput("t3_base", sw_clean, 10'h200);
        applyStimulus(10'h001, 1'b0, 5);
        checkOutput("t3_pre", sw_clean, 10'h200);
        applyStimulus(10'h001, 1'b0, 1);
        checkOutput("t3_clean", sw_clean, 10'h001);
        checkOutput("t3_rise", sw_rise, 10'h001);
        checkOutput("t3_fall", sw_fall, 10'h200);

        // 4: reset during a partial count discards the progress
        applyStimulus(10'h000, 1'b0, 8);
        applyStimulus(10'h00F, 1'b0, 5);
        resetPulse();
        applyStimulus(10'h00F, 1'b0, 5);
        checkOutput("t4_e5", sw_clean, 10'h000);
        applyStimulus(10'h00F, 1'b0, 1);
        checkOutput("t4_e6", sw_clean, 10'h00F);
        checkOutput("t4_rise", sw_rise, 10'h00F);

        // 5: CNT_MAX=1 instance, change at edge k seen at edge k+2
        applyStimulus(10'h00F, 1'b1, 1);
        checkOutput("t5_k", {9'b0, clean1}, 10'h000);
        applyStimulus(10'h00F, 1'b1, 1);
        checkOutput("t5_k1", {9'b0, clean1}, 10'h000);
        applyStimulus(10'h00F, 1'b1, 1);
        checkOutput("t5_k2", {9'b0, clean1}, 10'h001);
        checkOutput("t5_rise", {9'b0, rise1}, 10'h001);
        s1v = 1'b1;
        for (int n = 0; n < 10; n++) begin
            s1v = ~s1v;
            applyStimulus(10'h00F, s1v, 1);
        end

        // Random segments: held levels, short glitches and one mid-run reset
        sw_r = 10'($urandom);
        for (int n = 0; n < 70; n++) begin
            mask = 10'($urandom);
            s1v  = 1'($urandom);
            if ($urandom_range(0, 2) == 0) begin
                applyStimulus(sw_r ^ mask, s1v, $urandom_range(1, 3));
            end else begin
                sw_r = sw_r ^ mask;
            end
            applyStimulus(sw_r, 1'($urandom), $urandom_range(1, 8));
            if (n == 35) resetPulse();
        end
        applyStimulus(sw_r, 1'b0, 8);
        checkOutput("final_clean", sw_clean, sw_r);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
